// File: rtl/sm3_pkg.sv
// Shared SM3 constants, FSM encoding and round helper functions.
// Used by the round datapath and the compression engine top.
package sm3_pkg;

    localparam int WORD_WIDTH = 32;

    localparam logic [255:0] SM3_IV = {
        32'h7380166f, 32'h4914b2b9, 32'h172442d7, 32'hda8a0600,
        32'ha96f30bc, 32'h163138aa, 32'he38dee4d, 32'hb0fb0e4e
    };

    localparam logic [31:0] T_LOW  = 32'h79cc4519;
    localparam logic [31:0] T_HIGH = 32'h7a879d8a;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Rotate-left via a doubled word: the upper half of {x,x}<<n is x<<<n.
    function automatic logic [31:0] rotl(input logic [31:0] x, input logic [4:0] n);
        logic [63:0] w_dbl;
        w_dbl = {x, x} << n;
        return w_dbl[63:32];
    endfunction

    function automatic logic [31:0] p0(input logic [31:0] x);
        return x ^ rotl(x, 5'd9) ^ rotl(x, 5'd17);
    endfunction

    function automatic logic [31:0] ff_j(input logic [5:0] j, input logic [31:0] x,
                                         input logic [31:0] y, input logic [31:0] z);
        if (j < 6'd16)
            return x ^ y ^ z;
        return (x & y) | (x & z) | (y & z);
    endfunction

    function automatic logic [31:0] gg_j(input logic [5:0] j, input logic [31:0] x,
                                         input logic [31:0] y, input logic [31:0] z);
        if (j < 6'd16)
            return x ^ y ^ z;
        return (x & y) | (~x & z);
    endfunction

    function automatic logic [31:0] t_rot(input logic [5:0] j);
        return rotl((j < 6'd16) ? T_LOW : T_HIGH, j[4:0]);
    endfunction

endpackage

// File: rtl/sm3_round.sv
// One combinational SM3 compression round: {A..H} in, next {A..H} out.
// Chained UNROLL times inside the engine.
module sm3_round
    import sm3_pkg::*;
(
    input  logic [5:0]   i_j,
    input  logic [255:0] i_v,
    input  logic [31:0]  i_w,
    input  logic [31:0]  i_wp,
    output logic [255:0] o_v
);

    logic [31:0] w_a, w_b, w_c, w_d, w_e, w_f, w_g, w_h;
    logic [31:0] w_a12, w_ss1, w_ss2, w_tt1, w_tt2;

    assign {w_a, w_b, w_c, w_d, w_e, w_f, w_g, w_h} = i_v;

    assign w_a12 = rotl(w_a, 5'd12);
    assign w_ss1 = rotl(w_a12 + w_e + t_rot(i_j), 5'd7);
    assign w_ss2 = w_ss1 ^ w_a12;
    assign w_tt1 = ff_j(i_j, w_a, w_b, w_c) + w_d + w_ss2 + i_wp;
    assign w_tt2 = gg_j(i_j, w_e, w_f, w_g) + w_h + w_ss1 + i_w;

    assign o_v = {w_tt1, w_a, rotl(w_b, 5'd9), w_c,
                  p0(w_tt2), w_e, rotl(w_f, 5'd19), w_g};

endmodule

// File: rtl/sm3_compress_engine.sv
// SM3 compression engine: one 512-bit block per start, UNROLL rounds per accepted beat.
// Result {A..H}^V_saved is held on v_out until the consumer takes it.
module sm3_compress_engine #(
    parameter int UNROLL     = 1,
    parameter int WORD_WIDTH = 32
)(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_valid,
    output logic                  start_ready,
    input  logic                  use_iv,
    input  logic [255:0]          v_in,
    input  logic                  w_valid,
    output logic                  w_ready,
    input  logic [64*UNROLL-1:0]  w_data,
    input  logic                  abort,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [255:0]          v_out,
    output logic [1:0]            o_dbg_state
);

    if (WORD_WIDTH != sm3_pkg::WORD_WIDTH) begin : g_bad_word_width
        $error("sm3_compress_engine: WORD_WIDTH must be 32");
    end
    if (UNROLL != 1 && UNROLL != 2 && UNROLL != 4 && UNROLL != 8) begin : g_bad_unroll
        $error("sm3_compress_engine: UNROLL must be 1, 2, 4 or 8");
    end

    localparam logic [5:0] STEP     = 6'(UNROLL);
    localparam logic [5:0] LAST_CNT = 6'(64 - UNROLL);

    logic [1:0]   r_state;
    logic [5:0]   r_cnt;
    logic [255:0] r_v;
    logic [255:0] r_saved;
    logic [255:0] r_vout;
    logic         r_out_valid;

    logic [255:0] w_chain [UNROLL+1];
    logic         w_beat;

    assign w_chain[0] = r_v;

    for (genvar k = 0; k < UNROLL; k++) begin : g_round
        logic [5:0] w_j;
        assign w_j = r_cnt + 6'(k);
        sm3_round u_round (
            .i_j  (w_j),
            .i_v  (w_chain[k]),
            .i_w  (w_data[64*k+32 +: 32]),
            .i_wp (w_data[64*k +: 32]),
            .o_v  (w_chain[k+1])
        );
    end

    // Handshakes: a transfer happens on a rising edge where valid and ready are
    // both high. start_ready depends only on state (and rst); w_ready drops
    // under abort so an aborted cycle never consumes a beat.
    assign start_ready = (r_state == sm3_pkg::ST_IDLE) && !rst;
    assign w_ready     = (r_state == sm3_pkg::ST_RUN) && !abort;
    assign w_beat      = w_valid && w_ready;
    assign out_valid   = r_out_valid;
    assign v_out       = r_vout;
    assign o_dbg_state = r_state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= sm3_pkg::ST_IDLE;
            r_cnt       <= 6'd0;
            r_v         <= '0;
            r_saved     <= '0;
            r_vout      <= '0;
            r_out_valid <= 1'b0;
        end else if (abort) begin
            r_state     <= sm3_pkg::ST_IDLE;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                sm3_pkg::ST_IDLE: begin
                    if (start_valid) begin
                        r_v     <= use_iv ? sm3_pkg::SM3_IV : v_in;
                        r_saved <= use_iv ? sm3_pkg::SM3_IV : v_in;
                        r_cnt   <= 6'd0;
                        r_state <= sm3_pkg::ST_RUN;
                    end
                end
                sm3_pkg::ST_RUN: begin
                    if (w_beat) begin
                        r_v   <= w_chain[UNROLL];
                        r_cnt <= r_cnt + STEP;
                        if (r_cnt == LAST_CNT) begin
                            r_vout      <= w_chain[UNROLL] ^ r_saved;
                            r_out_valid <= 1'b1;
                            r_state     <= sm3_pkg::ST_DONE;
                        end
                    end
                end
                sm3_pkg::ST_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= sm3_pkg::ST_IDLE;
                    end
                end
                default: r_state <= sm3_pkg::ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sm3_compress_engine.sv
// Directed bench for sm3_compress_engine: UNROLL=1 and UNROLL=4 instances,
// scoreboard queue filled at start, monitor pops when out_valid appears.
`timescale 1ns/1ps
module tb_sm3_compress_engine;

    localparam logic [255:0] ABC_H  = 256'h66c7f0f4_62eeedd9_d1f2d46b_dc10e4e2_4167c487_5cf2f7a2_297da02b_8f4ba8e0;
    localparam logic [255:0] ABCD_H = 256'hdebe9ff9_2275b8a1_38604889_c18e5a4d_6fdb70e5_387e5765_293dcba3_9c0c5732;
    localparam logic [511:0] BLK_ABC   = {32'h61626380, 448'h0, 32'h00000018};
    localparam logic [511:0] BLK_ABCD1 = {16{32'h61626364}};
    localparam logic [511:0] BLK_ABCD2 = {32'h80000000, 448'h0, 32'h00000200};

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [1:0]   rst, start_valid, use_iv, w_valid, abort, out_ready;
    wire  [1:0]   start_ready, w_ready, out_valid;
    logic [255:0] v_in [2];
    logic [63:0]  w_data1;
    logic [255:0] w_data4;
    wire  [255:0] v_out1, v_out4;
    wire  [1:0]   dbg1, dbg4;

    sm3_compress_engine #(.UNROLL(1), .WORD_WIDTH(32)) u_dut1 (
        .clk(clk), .rst(rst[0]), .start_valid(start_valid[0]), .start_ready(start_ready[0]),
        .use_iv(use_iv[0]), .v_in(v_in[0]), .w_valid(w_valid[0]), .w_ready(w_ready[0]),
        .w_data(w_data1), .abort(abort[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .v_out(v_out1), .o_dbg_state(dbg1)
    );

    sm3_compress_engine #(.UNROLL(4), .WORD_WIDTH(32)) u_dut4 (
        .clk(clk), .rst(rst[1]), .start_valid(start_valid[1]), .start_ready(start_ready[1]),
        .use_iv(use_iv[1]), .v_in(v_in[1]), .w_valid(w_valid[1]), .w_ready(w_ready[1]),
        .w_data(w_data4), .abort(abort[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .v_out(v_out4), .o_dbg_state(dbg4)
    );

    // ---------------- scoreboard state ----------------
    typedef struct {
        logic         chk;
        logic [255:0] v;
        int           lat;
    } exp_t;

    exp_t         exp_q0[$];
    exp_t         exp_q1[$];
    int           n_checks = 0;
    int           n_fail   = 0;
    int           n_pushed [2] = '{0, 0};
    int           n_res    [2] = '{0, 0};
    int           start_cyc[2] = '{0, 0};
    logic         seen     [2] = '{1'b0, 1'b0};
    logic [255:0] held     [2];
    logic [255:0] last_out [2];

    logic [31:0] wm  [68];
    logic [31:0] wpm [64];

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: bound expired, required event never seen", name);
    endtask

    // ---------------- message expansion (stimulus only) ----------------
    function automatic logic [31:0] rl(input logic [31:0] x, input int n);
        return (x << n) | (x >> (32 - n));
    endfunction

    function automatic logic [31:0] p1(input logic [31:0] x);
        return x ^ rl(x, 15) ^ rl(x, 23);
    endfunction

    task automatic expand(input logic [511:0] blk);
        for (int i = 0; i < 16; i++) wm[i] = blk[511-32*i -: 32];
        for (int i = 16; i < 68; i++)
            wm[i] = p1(wm[i-16] ^ wm[i-9] ^ rl(wm[i-3], 15)) ^ rl(wm[i-13], 7) ^ wm[i-6];
        for (int i = 0; i < 64; i++) wpm[i] = wm[i] ^ wm[i+4];
    endtask

    // ---------------- driver tasks ----------------
    task automatic set_lanes(input int s, input int j);
        if (s == 0) begin
            w_data1 = {wm[j], wpm[j]};
        end else begin
            for (int k = 0; k < 4; k++) w_data4[64*k +: 64] = {wm[j+k], wpm[j+k]};
        end
    endtask

    task automatic start_blk(input int s, input logic iv, input logic [255:0] v, input logic push,
                             input logic chk, input logic [255:0] ev, input int lat, input logic keep);
        int   n;
        exp_t e;
        n = 0;
        start_valid[s] = 1'b1;
        use_iv[s]      = iv;
        v_in[s]        = v;
        #1;
        while (!start_ready[s] && n < 300) begin
            @(negedge clk); #1; n++;
        end
        if (n >= 300) fail_now("start_handshake");
        start_cyc[s] = cyc;
        if (push) begin
            e.chk = chk; e.v = ev; e.lat = lat;
            if (s == 0) exp_q0.push_back(e);
            else        exp_q1.push_back(e);
            n_pushed[s]++;
        end
        @(negedge clk);
        if (!keep) start_valid[s] = 1'b0;
    endtask

    task automatic feed(input int s, input int gap_pct, input int abort_at, input int rst_at);
        int j, guard, step;
        j = 0; guard = 0;
        step = (s == 0) ? 1 : 4;
        while (j < 64 && guard < 3000) begin
            if (j == abort_at) begin
                abort[s] = 1'b1; w_valid[s] = 1'b1; set_lanes(s, j);
                #1 check("w_ready_under_abort", 256'(w_ready[s]), 256'(0));
                @(negedge clk);
                abort[s] = 1'b0; w_valid[s] = 1'b0;
                #1;
                check("out_valid_after_abort", 256'(out_valid[s]), 256'(0));
                check("start_ready_after_abort", 256'(start_ready[s]), 256'(1));
                @(negedge clk);
                return;
            end
            if (j == rst_at) begin
                rst[s] = 1'b1; w_valid[s] = 1'b0;
                #1;
                check("rst_out_valid", 256'(out_valid[s]), 256'(0));
                check("rst_start_ready", 256'(start_ready[s]), 256'(0));
                check("rst_w_ready", 256'(w_ready[s]), 256'(0));
                check("rst_v_out", (s == 0) ? v_out1 : v_out4, 256'(0));
                @(negedge clk);
                rst[s] = 1'b0;
                #1 check("start_ready_after_rst", 256'(start_ready[s]), 256'(1));
                @(negedge clk);
                return;
            end
            w_valid[s] = !(gap_pct > 0 && $urandom_range(0, 99) < gap_pct);
            set_lanes(s, j);
            #1;
            if (w_valid[s] && w_ready[s]) j += step;
            @(negedge clk);
            guard++;
        end
        w_valid[s] = 1'b0;
        if (guard >= 3000) fail_now("beat_feed");
    endtask

    task automatic wait_out(input int s);
        int n;
        n = 0;
        #1;
        while (!out_valid[s] && n < 300) begin
            @(negedge clk); #1; n++;
        end
        if (n >= 300) fail_now("wait_out_valid");
    endtask

    task automatic wait_idle(input int s);
        int n;
        n = 0;
        #1;
        while (!start_ready[s] && n < 300) begin
            @(negedge clk); #1; n++;
        end
        if (n >= 300) fail_now("wait_idle");
        @(negedge clk);
    endtask

    // ---------------- monitor ----------------
    task automatic mon(input int s);
        logic [255:0] vo;
        exp_t         e;
        vo = (s == 0) ? v_out1 : v_out4;
        if (!out_valid[s]) begin
            seen[s] = 1'b0;
        end else begin
            if (!seen[s]) begin
                n_res[s]++;
                if ((s == 0 && exp_q0.size() == 0) || (s == 1 && exp_q1.size() == 0)) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_result dut%0d: out_valid=1 with v_out %h, required no result", s, vo);
                end else begin
                    if (s == 0) e = exp_q0.pop_front();
                    else        e = exp_q1.pop_front();
                    if (e.chk) check($sformatf("v_out_dut%0d", s), vo, e.v);
                    if (e.lat >= 0)
                        check($sformatf("latency_dut%0d", s), 256'(cyc - start_cyc[s]), 256'(e.lat));
                end
                held[s]     = vo;
                last_out[s] = vo;
                seen[s]     = 1'b1;
            end else begin
                check($sformatf("v_out_stable_dut%0d", s), vo, held[s]);
            end
            if (out_ready[s]) seen[s] = 1'b0;
        end
    endtask

    always @(negedge clk) begin
        #2;
        mon(0);
        mon(1);
    end

    initial begin
        #400000;
        $display("FAIL watchdog: time limit reached before end of test");
        $fatal(1, "watchdog");
    end

    // ---------------- test sequence ----------------
    initial begin
        rst = 2'b11; start_valid = 2'b00; use_iv = 2'b00; w_valid = 2'b00;
        abort = 2'b00; out_ready = 2'b11;
        v_in[0] = '0; v_in[1] = '0; w_data1 = '0; w_data4 = '0;
        repeat (2) @(negedge clk);
        #1;
        for (int s = 0; s < 2; s++) begin
            check("reset_start_ready", 256'(start_ready[s]), 256'(0));
            check("reset_w_ready", 256'(w_ready[s]), 256'(0));
            check("reset_out_valid", 256'(out_valid[s]), 256'(0));
        end
        check("reset_v_out1", v_out1, 256'(0));
        check("reset_v_out4", v_out4, 256'(0));
        check("reset_state1", 256'(dbg1), 256'(0));
        @(negedge clk);
        rst = 2'b00;
        #1;
        check("start_ready1_after_reset", 256'(start_ready[0]), 256'(1));
        check("start_ready4_after_reset", 256'(start_ready[1]), 256'(1));
        @(negedge clk);

        // "abc", UNROLL=1, no stalls
        expand(BLK_ABC);
        start_blk(0, 1'b1, '0, 1'b1, 1'b1, ABC_H, 65, 1'b0);
        feed(0, 0, -1, -1);
        wait_idle(0);

        // "abc", UNROLL=4, no stalls
        start_blk(1, 1'b1, '0, 1'b1, 1'b1, ABC_H, 17, 1'b0);
        feed(1, 0, -1, -1);
        wait_idle(1);

        // "abcd"x16 as two chained blocks, random gaps, consumer stalled on the last
        expand(BLK_ABCD1);
        start_blk(0, 1'b1, '0, 1'b1, 1'b0, '0, -1, 1'b0);
        feed(0, 30, -1, -1);
        wait_idle(0);
        expand(BLK_ABCD2);
        out_ready[0] = 1'b0;
        start_blk(0, 1'b0, last_out[0], 1'b1, 1'b1, ABCD_H, -1, 1'b0);
        feed(0, 30, -1, -1);
        wait_out(0);
        repeat (5) @(negedge clk);
        out_ready[0] = 1'b1;
        @(negedge clk);
        #1 check("out_valid_cleared_after_take", 256'(out_valid[0]), 256'(0));
        @(negedge clk);

        // abort at round 30, then a fresh "abc"
        expand(BLK_ABC);
        start_blk(0, 1'b1, '0, 1'b0, 1'b0, '0, -1, 1'b0);
        feed(0, 0, 30, -1);
        start_blk(0, 1'b1, '0, 1'b1, 1'b1, ABC_H, 65, 1'b0);
        feed(0, 0, -1, -1);
        wait_idle(0);

        // reset pulse at round 40, then a fresh "abc"
        start_blk(0, 1'b1, '0, 1'b0, 1'b0, '0, -1, 1'b0);
        feed(0, 0, -1, 40);
        start_blk(0, 1'b1, '0, 1'b1, 1'b1, ABC_H, 65, 1'b0);
        feed(0, 0, -1, -1);
        wait_idle(0);

        // start_valid held high through RUN and DONE
        start_blk(0, 1'b1, '0, 1'b1, 1'b1, ABC_H, 65, 1'b1);
        #1 check("start_ready_in_run", 256'(start_ready[0]), 256'(0));
        feed(0, 0, -1, -1);
        wait_out(0);
        check("start_ready_in_done", 256'(start_ready[0]), 256'(0));
        start_valid[0] = 1'b0;
        @(negedge clk);
        #1;
        check("idle_after_take", 256'(dbg1), 256'(0));
        check("start_ready_after_take", 256'(start_ready[0]), 256'(1));
        @(negedge clk);

        repeat (80) @(negedge clk);
        check("queue1_drained", 256'(exp_q0.size()), 256'(0));
        check("queue4_drained", 256'(exp_q1.size()), 256'(0));
        check("results1_count", 256'(n_res[0]), 256'(n_pushed[0]));
        check("results4_count", 256'(n_res[1]), 256'(n_pushed[1]));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sm3_compress_engine.md
SM3_COMPRESS_ENGINE -- requirements
Module: sm3_compress_engine

Interface
REQ-001 SHALL have parameter UNROLL, default 1, giving SM3 rounds per cycle; legal values 1, 2, 4, 8.
REQ-002 SHALL have parameter WORD_WIDTH, default 32, fixed at 32; any other value is a compile-time error.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port start_valid, input, 1 bit: a block request is present.
REQ-006 SHALL have port start_ready, output, 1 bit: the engine is idle and accepts a block.
REQ-007 SHALL have port use_iv, input, 1 bit: when 1 at start, load the standard IV instead of v_in.
REQ-008 SHALL have port v_in, input, 256 bits: chaining value {A..H}, with A in [255:224].
REQ-009 SHALL have port w_valid, input, 1 bit: a message-word beat is present.
REQ-010 SHALL have port w_ready, output, 1 bit: the engine consumes a beat this cycle.
REQ-011 SHALL have port w_data, input, 64*UNROLL bits: lane k occupies [64k+63:64k] and carries {W_j[63:32], W'_j[31:0]} for round j = cnt+k.
REQ-012 SHALL have port abort, input, 1 bit: synchronous cancel of the current block.
REQ-013 SHALL have port out_valid, output, 1 bit: the result is held on v_out.
REQ-014 SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-015 SHALL have port v_out, output, 256 bits: the compressed value {A..H} XOR V_saved.

Function
REQ-016 SHALL implement FSM IDLE -> RUN -> DONE -> IDLE.
REQ-017 SHALL drive start_ready=1 only in IDLE, w_ready=1 only in RUN, and out_valid=1 only in DONE.
REQ-018 SHALL, on start_valid&&start_ready, latch V_saved and the working registers A..H from v_in, or from IV 7380166f 4914b2b9 172442d7 da8a0600 a96f30bc 163138aa e38dee4d b0fb0e4e when use_iv=1; clear cnt to 0; and enter RUN.
REQ-019 SHALL, in RUN on w_valid&&w_ready, apply UNROLL chained rounds j=cnt..cnt+UNROLL-1 and advance cnt by UNROLL; with w_valid=0, hold all state (stall).
REQ-020 SHALL compute each round per GB/T 32905, all arithmetic mod 2^32:
- T_j = 79cc4519 for j<16, else 7a879d8a.
- SS1 = ((A<<<12)+E+(T_j<<<(j mod 32)))<<<7; SS2 = SS1^(A<<<12).
- FF/GG: XOR for j<16; majority / (E&F)|(~E&G) for j>=16.
- TT1 = FF+D+SS2+W'_j; TT2 = GG+H+SS1+W_j.
- Update: D=C, C=B<<<9, B=A, A=TT1, H=G, G=F<<<19, F=E, E=P0(TT2), where P0(x) = x^(x<<<9)^(x<<<17).
REQ-021 SHALL use a 6-bit cnt; when the beat that covers round 63 is accepted, move to DONE and register v_out = {A..H}^V_saved.
REQ-022 SHALL give a latency, with no stalls, from the start handshake at cycle t to the final beat at cycle t+64/UNROLL, with out_valid=1 from cycle t+64/UNROLL+1.
REQ-023 SHALL hold out_valid and v_out stable in DONE until out_ready=1; the handshake returns to IDLE and clears out_valid the next cycle.
REQ-024 SHALL NOT accept a start in the same cycle as the out handshake; start is accepted the following cycle at the earliest.
REQ-025 SHALL, on abort=1 in any state, go to IDLE on the next edge with out_valid=0 and no beat consumed; abort has priority over w and out handshakes.
REQ-026 SHALL ignore start_valid while not IDLE; the result in v_out is unaffected.

Reset
REQ-027 SHALL, while rst=1, force state=IDLE, cnt=0, A..H=0, V_saved=0, v_out=0, out_valid=0, w_ready=0, and start_ready=0.
REQ-028 SHALL assert start_ready=1 in the first cycle after rst deasserts.
REQ-029 SHALL, when rst asserts mid-RUN or mid-DONE, discard the block; no partial result becomes visible.

Structure
REQ-030 SHALL place WORD_WIDTH, the IV, T constants, the state encoding, and the rotl/P0/FF/GG functions in shared package sm3_pkg.
REQ-031 SHALL implement one round as combinational sub-module sm3_round (inputs j, {A..H}, W_j, W'_j; output the next {A..H}), instantiated UNROLL times in a chain.
REQ-032 SHALL reject at elaboration any UNROLL value outside {1,2,4,8}.

Verification
REQ-033 SHALL cover: UNROLL=1, use_iv=1, padded "abc" W stream, no stalls -> v_out = 66c7f0f4 62eeedd9 d1f2d46b dc10e4e2 4167c487 5cf2f7a2 297da02b 8f4ba8e0, with out_valid exactly 65 cycles after start.
REQ-034 SHALL cover: UNROLL=4, the same "abc" stimulus -> same v_out, with out_valid 17 cycles after start.
REQ-035 SHALL cover: "abcd"x16 as two chained blocks (second block v_in = first block v_out), with random w_valid gaps and out_ready held low 5 cycles -> v_out = debe9ff9 2275b8a1 38604889 c18e5a4d 6fdb70e5 387e5765 293dcba3 9c0c5732, with v_out stable while stalled.
REQ-036 SHALL cover: abort at round 30, then a new "abc" block -> no out_valid for the aborted block, and the correct "abc" result.
REQ-037 SHALL cover: rst pulse during RUN at round 40 -> all outputs 0 immediately, start_ready=1 after release, and a subsequent block correct.
REQ-038 SHALL cover: start_valid held high during RUN and DONE -> exactly one block processed per start handshake.
